operand_streamer: RTL and testbench
===================================

OPERAND_STREAMER -- requirements
Module: operand_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning stream data width in bits.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, meaning width of the per-phase beat counts.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have ports cmd_vld in 1, cmd_rdy out 1, cmd_w_len in LEN_WIDTH, cmd_x_len in LEN_WIDTH: command handshake carrying the weight beat count and the activation beat count.
REQ-006 SHALL have ports in_vld in 1, in_rdy out 1, in_data in DATA_WIDTH: the raw operand stream from memory.
REQ-007 SHALL have ports src_vld out 1, src_rdy in 1, src_data out DATA_WIDTH: the operand stream to the matrix core.
REQ-008 SHALL have port load_state, output, 3, the phase tag for the current src beat, matching the matrix core's load_state encoding.
REQ-009 SHALL have port compute_done, input, 1, a one-cycle pulse from the matrix core ending COMPUTE.
REQ-010 SHALL have ports busy, output, 1, high when not IDLE, and done, output, 1, a one-cycle pulse on return to IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, LOAD_W, LOAD_X and COMPUTE, with load_state equal to the package code of the current state.
REQ-012 SHALL drive cmd_rdy=1 only in IDLE; a command is accepted on cmd_vld&&cmd_rdy, and its lengths are latched that cycle.
REQ-013 SHALL leave IDLE on command acceptance, going to LOAD_W if w_len!=0, else LOAD_X if x_len!=0, else COMPUTE.
REQ-014 SHALL count a beat in LOAD_W/LOAD_X on each src_vld&&src_rdy handshake, and advance on the handshake of the last beat of the phase (count==len-1).
REQ-015 SHALL advance from LOAD_W to LOAD_X, or to COMPUTE if x_len==0.
REQ-016 SHALL advance from LOAD_X to COMPUTE.
REQ-017 SHALL advance from COMPUTE to IDLE on compute_done, asserting done for exactly that transition cycle.
REQ-018 SHALL ignore compute_done outside COMPUTE.
REQ-019 SHALL hold in_rdy=0 and src_vld=0 outside LOAD_W/LOAD_X, so no beat ever leaks between commands or into COMPUTE.
REQ-020 SHALL, in the default (pass-through) mode, give src_data=in_data, src_vld=in_vld and in_rdy=src_rdy within the load states: zero latency, combinational.
REQ-021 SHALL implement counters LEN_WIDTH bits wide, with a length of 2^LEN_WIDTH-1 meaning that many beats (no wrap inside a phase).
REQ-022 SHALL treat a stall (src_rdy=0) of any duration as holding state, counters and src_data stable.

Reset
REQ-023 SHALL, on rst assertion, immediately set state=IDLE, counters=0, cmd_rdy=1, busy=0, done=0, src_vld=0, in_rdy=0 and load_state=IDLE code, including when rst arrives mid-phase.
REQ-024 SHALL discard on reset any partially transferred command, and any skid-buffered beats.

Configuration
REQ-025 SHALL, with OPERAND_STREAMER_SKID_EN defined, insert a 2-entry skid buffer on the src side.
REQ-026 SHALL, with the skid buffer compiled in, have src_vld/src_data/load_state registered, 1-cycle latency, in_rdy registered, and accept-side beats counted separately so that no beat beyond len is accepted.
REQ-027 SHALL, with the skid buffer compiled in, take phase transitions on output handshakes.
REQ-028 SHALL, with the macro undefined, provide the pass-through behaviour of REQ-020.

Structure
REQ-029 SHALL take DATA_WIDTH and the state codes MATRIX_CORE_IDLE=0, MATRIX_CORE_LOAD_W=1, MATRIX_CORE_LOAD_X=2, MATRIX_CORE_COMPUTE=3 from constants_pkg, shared with the matrix core.
REQ-030 SHALL implement the optional buffer as sub-module stream_skid_buffer.

Verification
REQ-031 SHALL pass: cmd w_len=3, x_len=2, src_rdy=1, data 0x10..0x14 -> 3 beats tagged 1 then 2 beats tagged 2; COMPUTE; compute_done -> done pulse, IDLE.
REQ-032 SHALL pass: w_len=0, x_len=4 -> LOAD_W skipped; the first beat is tagged LOAD_X.
REQ-033 SHALL pass: w_len=0, x_len=0 -> COMPUTE the cycle after acceptance, with in_rdy never asserted.
REQ-034 SHALL pass: w_len=4, src_rdy toggled 1/0 -> exactly 4 handshakes, data order preserved, no extra in_rdy after the 4th.
REQ-035 SHALL pass: rst asserted after 2 of 3 W beats -> same-cycle outputs per REQ-023; a new command restarts from count 0.
REQ-036 SHALL pass: compute_done pulsed during LOAD_X -> ignored, with the transfer completing normally.

Source files
------------

// File: rtl/constants_pkg.sv
// Constants shared between the operand streamer and the matrix core:
// the default stream width and the load_state phase codes.
package constants_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [2:0] MATRIX_CORE_IDLE    = 3'd0;
  localparam logic [2:0] MATRIX_CORE_LOAD_W  = 3'd1;
  localparam logic [2:0] MATRIX_CORE_LOAD_X  = 3'd2;
  localparam logic [2:0] MATRIX_CORE_COMPUTE = 3'd3;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready skid buffer: registered out_vld/out_data and in_rdy,
// full throughput, contents cleared by reset.
module stream_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data
);

  logic             main_vld_reg;
  logic [WIDTH-1:0] main_data_reg;
  logic             skid_vld_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             in_fire;

  assign in_rdy   = !skid_vld_reg;
  assign out_vld  = main_vld_reg;
  assign out_data = main_data_reg;
  assign in_fire  = in_vld && in_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_reg  <= 1'b0;
      main_data_reg <= '0;
      skid_vld_reg  <= 1'b0;
      skid_data_reg <= '0;
    end else if (out_rdy || !main_vld_reg) begin
      // Output slot is free this cycle: refill from skid first, else from input.
      if (skid_vld_reg) begin
        main_data_reg <= skid_data_reg;
        main_vld_reg  <= 1'b1;
        skid_vld_reg  <= 1'b0;
      end else begin
        main_data_reg <= in_data;
        main_vld_reg  <= in_fire;
      end
    end else if (in_fire) begin
      skid_data_reg <= in_data;
      skid_vld_reg  <= 1'b1;
    end
  end

endmodule

// File: rtl/operand_streamer.sv
// Sequences weight then activation beats to the matrix core and waits for
// COMPUTE to finish. OPERAND_STREAMER_SKID_EN adds a registered skid buffer.
module operand_streamer
  import constants_pkg::*;
#(
  parameter int DATA_WIDTH = constants_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [LEN_WIDTH-1:0]  cmd_w_len,
  input  logic [LEN_WIDTH-1:0]  cmd_x_len,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  src_vld,
  input  logic                  src_rdy,
  output logic [DATA_WIDTH-1:0] src_data,
  output logic [2:0]            load_state,
  input  logic                  compute_done,
  output logic                  busy,
  output logic                  done
);

  logic [2:0]           state_reg, state_next;
  logic [LEN_WIDTH-1:0] w_len_reg, x_len_reg;
  logic [LEN_WIDTH-1:0] cnt_reg, cnt_next;
  logic [LEN_WIDTH-1:0] cur_len;
  logic                 in_load, cmd_fire, out_fire, out_last;

  assign in_load  = (state_reg == MATRIX_CORE_LOAD_W) || (state_reg == MATRIX_CORE_LOAD_X);
  assign cur_len  = (state_reg == MATRIX_CORE_LOAD_W) ? w_len_reg : x_len_reg;
  assign cmd_fire = cmd_vld && cmd_rdy;
  assign out_fire = src_vld && src_rdy;
  assign out_last = (cnt_reg == cur_len - LEN_WIDTH'(1));

  assign cmd_rdy    = (state_reg == MATRIX_CORE_IDLE);
  assign busy       = (state_reg != MATRIX_CORE_IDLE);
  assign done       = (state_reg == MATRIX_CORE_COMPUTE) && compute_done;
  assign load_state = state_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      MATRIX_CORE_IDLE: begin
        cnt_next = '0;
        if (cmd_fire) begin
          if (cmd_w_len != '0)      state_next = MATRIX_CORE_LOAD_W;
          else if (cmd_x_len != '0) state_next = MATRIX_CORE_LOAD_X;
          else                      state_next = MATRIX_CORE_COMPUTE;
        end
      end
      MATRIX_CORE_LOAD_W: begin
        if (out_fire) begin
          if (out_last) begin
            cnt_next   = '0;
            state_next = (x_len_reg != '0) ? MATRIX_CORE_LOAD_X : MATRIX_CORE_COMPUTE;
          end else begin
            cnt_next = cnt_reg + LEN_WIDTH'(1);
          end
        end
      end
      MATRIX_CORE_LOAD_X: begin
        if (out_fire) begin
          if (out_last) begin
            cnt_next   = '0;
            state_next = MATRIX_CORE_COMPUTE;
          end else begin
            cnt_next = cnt_reg + LEN_WIDTH'(1);
          end
        end
      end
      MATRIX_CORE_COMPUTE: begin
        if (compute_done) state_next = MATRIX_CORE_IDLE;
      end
      default: state_next = MATRIX_CORE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= MATRIX_CORE_IDLE;
      cnt_reg   <= '0;
      w_len_reg <= '0;
      x_len_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (cmd_fire) begin
        w_len_reg <= cmd_w_len;
        x_len_reg <= cmd_x_len;
      end
    end
  end

`ifdef OPERAND_STREAMER_SKID_EN
  // Accept side runs its own phase/count so the buffer never takes a beat past len.
  logic [2:0]           acc_state_reg;
  logic [LEN_WIDTH-1:0] acc_cnt_reg;
  logic [LEN_WIDTH-1:0] acc_len;
  logic                 acc_active, acc_last, in_fire, buf_in_vld, buf_in_rdy;

  assign acc_active = (acc_state_reg == MATRIX_CORE_LOAD_W) || (acc_state_reg == MATRIX_CORE_LOAD_X);
  assign acc_len    = (acc_state_reg == MATRIX_CORE_LOAD_W) ? w_len_reg : x_len_reg;
  assign acc_last   = (acc_cnt_reg == acc_len - LEN_WIDTH'(1));
  assign buf_in_vld = in_vld && acc_active;
  assign in_rdy     = buf_in_rdy && acc_active;
  assign in_fire    = in_vld && in_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_state_reg <= MATRIX_CORE_IDLE;
      acc_cnt_reg   <= '0;
    end else if (cmd_fire) begin
      acc_cnt_reg <= '0;
      if (cmd_w_len != '0)      acc_state_reg <= MATRIX_CORE_LOAD_W;
      else if (cmd_x_len != '0) acc_state_reg <= MATRIX_CORE_LOAD_X;
      else                      acc_state_reg <= MATRIX_CORE_IDLE;
    end else if (in_fire) begin
      if (acc_last) begin
        acc_cnt_reg   <= '0;
        acc_state_reg <= (acc_state_reg == MATRIX_CORE_LOAD_W && x_len_reg != '0)
                         ? MATRIX_CORE_LOAD_X : MATRIX_CORE_IDLE;
      end else begin
        acc_cnt_reg <= acc_cnt_reg + LEN_WIDTH'(1);
      end
    end
  end

  stream_skid_buffer #(
    .WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (buf_in_vld),
    .in_rdy   (buf_in_rdy),
    .in_data  (in_data),
    .out_vld  (src_vld),
    .out_rdy  (src_rdy),
    .out_data (src_data)
  );
`else
  assign src_vld  = in_load && in_vld;
  assign in_rdy   = in_load && src_rdy;
  assign src_data = in_data;
`endif

endmodule

// File: tb/tb_operand_streamer.sv
// Scoreboard bench for operand_streamer: stimulus pushes expected {tag,data}
// beats, a negedge monitor pops and compares on every src handshake.
module tb_operand_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic [7:0] cmd_w_len, cmd_x_len;
  logic       in_vld;
  logic       in_rdy;
  logic [7:0] in_data;
  logic       src_vld;
  logic       src_rdy;
  logic [7:0] src_data;
  logic [2:0] load_state;
  logic       compute_done;
  logic       busy;
  logic       done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int pop_cnt   = 0;
  int done_cnt  = 0;
  int leak_cnt  = 0;
  bit toggle_rdy = 1'b0;

  logic [10:0] exp_q[$];
  logic [7:0]  feed_q[$];

  always #5 clk = ~clk;

  operand_streamer #(
    .DATA_WIDTH (8),
    .LEN_WIDTH  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_vld      (cmd_vld),
    .cmd_rdy      (cmd_rdy),
    .cmd_w_len    (cmd_w_len),
    .cmd_x_len    (cmd_x_len),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .in_data      (in_data),
    .src_vld      (src_vld),
    .src_rdy      (src_rdy),
    .src_data     (src_data),
    .load_state   (load_state),
    .compute_done (compute_done),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s: got %0h", name, act);
    end else begin
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard comparison per src handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && src_vld && src_rdy) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("beat_unexpected", {21'd0, load_state, src_data}, 32'hFFFF_FFFF);
        end else begin
          check("beat", {21'd0, load_state, src_data}, {21'd0, exp_q.pop_front()});
        end
      end
      if (done) done_cnt++;
      if ((in_rdy || src_vld) && load_state != 3'd1 && load_state != 3'd2) leak_cnt++;
    end
  end

  // Upstream memory model: presents feed_q head, pops on in handshake.
  initial begin
    bit f;
    in_vld  = 1'b0;
    in_data = 8'h00;
    forever begin
      @(negedge clk);
      f = in_vld && in_rdy && !rst;
      @(posedge clk);
      #1;
      if (f && feed_q.size() > 0) void'(feed_q.pop_front());
      #1;
      in_vld  = (feed_q.size() > 0);
      in_data = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
    end
  end

  initial begin
    src_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      src_rdy = toggle_rdy ? ~src_rdy : 1'b1;
    end
  end

  task automatic send_cmd(input logic [7:0] w, input logic [7:0] x);
    @(posedge clk);
    #1;
    cmd_vld   = 1'b1;
    cmd_w_len = w;
    cmd_x_len = x;
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] code, input string name);
    int n = 0;
    while (load_state !== code && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, {29'd0, load_state}, {29'd0, code});
  endtask

  task automatic finish_compute(input string name);
    @(posedge clk);
    #1;
    compute_done = 1'b1;
    @(negedge clk);
    check({name, "_done"}, {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    compute_done = 1'b0;
    check({name, "_idle"}, {29'd0, load_state}, 32'd0);
    check({name, "_cmd_rdy"}, {31'd0, cmd_rdy}, 32'd1);
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    cmd_vld      = 1'b0;
    cmd_w_len    = 8'd0;
    cmd_x_len    = 8'd0;
    compute_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_src_vld", {31'd0, src_vld}, 32'd0);
    check("rst_load_state", {29'd0, load_state}, 32'd0);
    #1 rst = 1'b0;

    // w=3, x=2: 3 beats tagged LOAD_W then 2 tagged LOAD_X
    feed_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    exp_q  = '{{3'd1, 8'h10}, {3'd1, 8'h11}, {3'd1, 8'h12}, {3'd2, 8'h13}, {3'd2, 8'h14}};
    send_cmd(8'd3, 8'd2);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_state(3'd3, "t1_compute");
    finish_compute("t1");

    // w=0, x=4: first beat already tagged LOAD_X
    feed_q = '{8'h20, 8'h21, 8'h22, 8'h23};
    exp_q  = '{{3'd2, 8'h20}, {3'd2, 8'h21}, {3'd2, 8'h22}, {3'd2, 8'h23}};
    send_cmd(8'd0, 8'd4);
    check("t2_first_phase", {29'd0, load_state}, 32'd2);
    wait_state(3'd3, "t2_compute");
    finish_compute("t2");

    // w=0, x=0: straight to COMPUTE
    send_cmd(8'd0, 8'd0);
    check("t3_compute_next", {29'd0, load_state}, 32'd3);
    finish_compute("t3");

    // w=4 with src_rdy toggling and a spare fifth word that must stay put
    toggle_rdy = 1'b1;
    feed_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
    exp_q  = '{{3'd1, 8'h30}, {3'd1, 8'h31}, {3'd1, 8'h32}, {3'd1, 8'h33}};
    send_cmd(8'd4, 8'd0);
    wait_state(3'd3, "t4_compute");
    repeat (3) @(negedge clk);
    check("t4_spare_left", feed_q.size(), 32'd1);
    toggle_rdy = 1'b0;
    feed_q.delete();
    finish_compute("t4");

    // reset after 2 of 3 W beats, then a fresh command
    feed_q = '{8'h40, 8'h41, 8'h42};
    exp_q  = '{{3'd1, 8'h40}, {3'd1, 8'h41}, {3'd1, 8'h42}};
    n = pop_cnt;
    send_cmd(8'd3, 8'd0);
    for (int i = 0; i < 200 && pop_cnt < n + 2; i++) @(negedge clk);
    check("t5_two_beats", pop_cnt - n, 32'd2);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_state", {29'd0, load_state}, 32'd0);
    check("t5_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_in_rdy", {31'd0, in_rdy}, 32'd0);
    check("t5_rst_src_vld", {31'd0, src_vld}, 32'd0);
    exp_q.delete();
    feed_q.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    feed_q = '{8'h50, 8'h51, 8'h52};
    exp_q  = '{{3'd1, 8'h50}, {3'd1, 8'h51}, {3'd2, 8'h52}};
    send_cmd(8'd2, 8'd1);
    wait_state(3'd3, "t5_compute");
    finish_compute("t5");

    // compute_done during LOAD_X is ignored
    feed_q = '{8'h60, 8'h61, 8'h62, 8'h63};
    exp_q  = '{{3'd1, 8'h60}, {3'd2, 8'h61}, {3'd2, 8'h62}, {3'd2, 8'h63}};
    send_cmd(8'd1, 8'd3);
    wait_state(3'd2, "t6_load_x");
    @(posedge clk);
    #1 compute_done = 1'b1;
    @(negedge clk);
    check("t6_no_done", {31'd0, done}, 32'd0);
    check("t6_still_x", {29'd0, load_state}, 32'd2);
    @(posedge clk);
    #1 compute_done = 1'b0;
    wait_state(3'd3, "t6_compute");
    finish_compute("t6");

    repeat (2) @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);
    check("no_leak", leak_cnt, 32'd0);
    check("done_pulses", done_cnt, 32'd6);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
